filter_mode_ctrl: RTL and testbench

FILTER_MODE_CTRL -- requirements
Module: filter_mode_ctrl

---
 rtl/filter_mode_ctrl.sv | 164 ++++++++++++++++
 tb/tb_filter_mode_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_mode_ctrl.sv
// Filter mode controller: applies host mode/threshold requests on video frame edges.
// Optional auto-cycle of modes every FRAMES_PER_MODE frames when FILTER_AUTOCYCLE_EN is defined.
module filter_mode_ctrl #(
  parameter int FRAMES_PER_MODE = 60
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       VSync,
  input  logic       ReqValid,
  output logic       ReqReady,
  input  logic [2:0] ReqMode,
  input  logic [7:0] ReqThresh1,
  input  logic [7:0] ReqThresh2,
  input  logic       AutoEn,
  output logic [5:0] Display,
  output logic [7:0] Thresh1,
  output logic [7:0] Thresh2,
  output logic [2:0] ModeOut,
  output logic       Busy,
  output logic       Done
);

  typedef enum logic {
    IDLE,
    PENDING
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       vsync_q;
  logic       rel_hold;
  logic       fe;
  logic       accept;
  logic       apply;
  logic       auto_step;
  logic [2:0] auto_mode;
  logic [2:0] shadow_mode;
  logic [7:0] shadow_t1;
  logic [7:0] shadow_t2;

  function automatic logic [5:0] mode_to_display(input logic [2:0] m);
    logic [5:0] d;
    d = 6'b000000;
    case (m)
      3'd1:    d = 6'b000001;
      3'd2:    d = 6'b000010;
      3'd3:    d = 6'b000100;
      3'd4:    d = 6'b001000;
      3'd5:    d = 6'b010000;
      3'd6:    d = 6'b100000;
      default: d = 6'b000000;
    endcase
    return d;
  endfunction

  // rel_hold masks the first cycle after reset so a VSync already high at release is not an edge
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vsync_q  <= 1'b0;
      rel_hold <= 1'b1;
    end else begin
      vsync_q  <= VSync;
      rel_hold <= 1'b0;
    end
  end

  assign fe = VSync & ~vsync_q & ~rel_hold;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    apply      = 1'b0;
    case (state)
      IDLE: begin
        if (ReqValid) begin
          accept     = 1'b1;
          state_next = PENDING;
        end
      end
      PENDING: begin
        if (fe) begin
          apply      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ReqReady = (state == IDLE);
  assign Busy     = (state == PENDING);

  // Mode 7 is folded to passthrough at capture so everything downstream only sees 0..6
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shadow_mode <= 3'd0;
      shadow_t1   <= 8'd200;
      shadow_t2   <= 8'd255;
    end else if (accept) begin
      shadow_mode <= (ReqMode == 3'd7) ? 3'd0 : ReqMode;
      shadow_t1   <= ReqThresh1;
      shadow_t2   <= ReqThresh2;
    end
  end

`ifdef FILTER_AUTOCYCLE_EN
  localparam logic [7:0] LastCount = 8'(FRAMES_PER_MODE - 1);

  logic [7:0] frame_cnt;

  // Any host activity or a disabled auto-cycle restarts the frame count from zero
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      frame_cnt <= 8'd0;
    end else if ((state != IDLE) || !AutoEn || accept) begin
      frame_cnt <= 8'd0;
    end else if (fe) begin
      frame_cnt <= (frame_cnt == LastCount) ? 8'd0 : frame_cnt + 8'd1;
    end
  end

  assign auto_step = (state == IDLE) && AutoEn && !accept && fe && (frame_cnt == LastCount);
  assign auto_mode = (ModeOut >= 3'd6) ? 3'd0 : ModeOut + 3'd1;
`else
  logic       unused_autoen;
  logic [7:0] unused_frames;

  assign unused_autoen = AutoEn;
  assign unused_frames = 8'(FRAMES_PER_MODE);
  assign auto_step     = 1'b0;
  assign auto_mode     = 3'd0;
`endif

  // All visible settings update together, and only on a frame-edge cycle
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ModeOut <= 3'd0;
      Display <= 6'b000000;
      Thresh1 <= 8'd200;
      Thresh2 <= 8'd255;
      Done    <= 1'b0;
    end else begin
      Done <= apply;
      if (apply) begin
        ModeOut <= shadow_mode;
        Display <= mode_to_display(shadow_mode);
        Thresh1 <= shadow_t1;
        Thresh2 <= shadow_t2;
      end else if (auto_step) begin
        ModeOut <= auto_mode;
        Display <= mode_to_display(auto_mode);
      end
    end
  end

endmodule

// File: tb/tb_filter_mode_ctrl.sv
// Scoreboard bench for filter_mode_ctrl: expected applied settings are queued on
// acceptance and popped by a monitor on every Done pulse.
module tb_filter_mode_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       VSync = 1'b0;
  logic       ReqValid = 1'b0;
  logic       ReqReady;
  logic [2:0] ReqMode = 3'd0;
  logic [7:0] ReqThresh1 = 8'd0;
  logic [7:0] ReqThresh2 = 8'd0;
  logic       AutoEn = 1'b0;
  logic [5:0] Display;
  logic [7:0] Thresh1;
  logic [7:0] Thresh2;
  logic [2:0] ModeOut;
  logic       Busy;
  logic       Done;

  typedef struct packed {
    logic [2:0] mode;
    logic [5:0] disp;
    logic [7:0] t1;
    logic [7:0] t2;
  } exp_t;

  exp_t sbQueue[$];
  int   checks = 0;
  int   failures = 0;

  filter_mode_ctrl #(.FRAMES_PER_MODE(2)) dut (
    .CLK(CLK),
    .RST(RST),
    .VSync(VSync),
    .ReqValid(ReqValid),
    .ReqReady(ReqReady),
    .ReqMode(ReqMode),
    .ReqThresh1(ReqThresh1),
    .ReqThresh2(ReqThresh2),
    .AutoEn(AutoEn),
    .Display(Display),
    .Thresh1(Thresh1),
    .Thresh2(Thresh2),
    .ModeOut(ModeOut),
    .Busy(Busy),
    .Done(Done)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic frameEdge();
    VSync = 1'b1;
    tick(2);
    VSync = 1'b0;
    tick(2);
  endtask

  task automatic applyStimulus(input logic [2:0] mode, input logic [7:0] t1, input logic [7:0] t2,
                               input logic [2:0] expMode, input logic [5:0] expDisp, input bit track);
    int guard;
    exp_t e;
    ReqMode    = mode;
    ReqThresh1 = t1;
    ReqThresh2 = t2;
    ReqValid   = 1'b1;
    guard      = 0;
    while (!ReqReady && guard < 100) begin
      tick(1);
      guard++;
    end
    if (!ReqReady) begin
      checkOutput("req_ready_timeout", 32'(ReqReady), 1);
      ReqValid = 1'b0;
      return;
    end
    tick(1);
    ReqValid = 1'b0;
    if (track) begin
      e = '{mode: expMode, disp: expDisp, t1: t1, t2: t2};
      sbQueue.push_back(e);
    end
    checkOutput("busy_after_accept", 32'(Busy), 1);
  endtask

  // Every Done pulse must match the oldest outstanding request
  always @(negedge CLK) begin
    exp_t e;
    if (RST === 1'b1 && Done === 1'b1) begin
      if (sbQueue.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done: got Done=1 expected no Done (queue empty)");
      end else begin
        e = sbQueue.pop_front();
        checkOutput("sb_mode", 32'(ModeOut), 32'(e.mode));
        checkOutput("sb_display", 32'(Display), 32'(e.disp));
        checkOutput("sb_thresh1", 32'(Thresh1), 32'(e.t1));
        checkOutput("sb_thresh2", 32'(Thresh2), 32'(e.t2));
      end
    end
  end

  initial begin
    exp_t e;
    tick(3);
    checkOutput("rst_display", 32'(Display), 0);
    checkOutput("rst_thresh1", 32'(Thresh1), 200);
    checkOutput("rst_thresh2", 32'(Thresh2), 255);
    checkOutput("rst_mode", 32'(ModeOut), 0);
    checkOutput("rst_ready", 32'(ReqReady), 1);
    checkOutput("rst_busy", 32'(Busy), 0);
    checkOutput("rst_done", 32'(Done), 0);
    RST = 1'b1;
    tick(3);

    // basic request applied at the next frame edge
    applyStimulus(3'd3, 8'd128, 8'd64, 3'd3, 6'b000100, 1'b1);
    tick(3);
    checkOutput("basic_busy_midframe", 32'(Busy), 1);
    checkOutput("basic_display_midframe", 32'(Display), 0);
    frameEdge();
    checkOutput("basic_ready_after", 32'(ReqReady), 1);
    checkOutput("basic_busy_after", 32'(Busy), 0);

    // acceptance on the frame-edge cycle waits for the following edge
    ReqMode    = 3'd1;
    ReqThresh1 = 8'd10;
    ReqThresh2 = 8'd20;
    ReqValid   = 1'b1;
    VSync      = 1'b1;
    tick(1);
    ReqValid = 1'b0;
    e = '{mode: 3'd1, disp: 6'b000001, t1: 8'd10, t2: 8'd20};
    sbQueue.push_back(e);
    tick(2);
    checkOutput("coinc_mode_held", 32'(ModeOut), 3);
    checkOutput("coinc_display_held", 32'(Display), 6'b000100);
    checkOutput("coinc_busy", 32'(Busy), 1);
    VSync = 1'b0;
    tick(2);
    frameEdge();

    // backpressure: second request held until the first is applied
    ReqMode    = 3'd2;
    ReqThresh1 = 8'd30;
    ReqThresh2 = 8'd40;
    ReqValid   = 1'b1;
    checkOutput("bp_ready_idle", 32'(ReqReady), 1);
    tick(1);
    e = '{mode: 3'd2, disp: 6'b000010, t1: 8'd30, t2: 8'd40};
    sbQueue.push_back(e);
    ReqMode    = 3'd5;
    ReqThresh1 = 8'd50;
    ReqThresh2 = 8'd60;
    tick(3);
    checkOutput("bp_ready_low", 32'(ReqReady), 0);
    checkOutput("bp_busy", 32'(Busy), 1);
    VSync = 1'b1;
    tick(1);
    checkOutput("bp_ready_back", 32'(ReqReady), 1);
    tick(1);
    ReqValid = 1'b0;
    e = '{mode: 3'd5, disp: 6'b010000, t1: 8'd50, t2: 8'd60};
    sbQueue.push_back(e);
    checkOutput("bp_second_busy", 32'(Busy), 1);
    VSync = 1'b0;
    tick(2);
    frameEdge();

    // mode 7 behaves as passthrough
    applyStimulus(3'd7, 8'd77, 8'd88, 3'd0, 6'b000000, 1'b1);
    frameEdge();

    // reset while pending discards the request
    applyStimulus(3'd4, 8'd11, 8'd22, 3'd4, 6'b001000, 1'b0);
    tick(2);
    RST = 1'b0;
    #2;
    checkOutput("rstp_display", 32'(Display), 0);
    checkOutput("rstp_thresh1", 32'(Thresh1), 200);
    checkOutput("rstp_thresh2", 32'(Thresh2), 255);
    checkOutput("rstp_ready", 32'(ReqReady), 1);
    checkOutput("rstp_busy", 32'(Busy), 0);
    checkOutput("rstp_done", 32'(Done), 0);
    checkOutput("rstp_mode", 32'(ModeOut), 0);
    tick(2);
    RST = 1'b1;
    tick(2);
    frameEdge();
    checkOutput("rstp_mode_after_fe", 32'(ModeOut), 0);
    checkOutput("rstp_busy_after_fe", 32'(Busy), 0);

`ifdef FILTER_AUTOCYCLE_EN
    begin
      logic [2:0] autoModes [7];
      logic [5:0] autoDisps [7];
      logic [2:0] prevMode;
      autoModes = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
      autoDisps = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000, 6'b000000};
      prevMode  = 3'd0;
      AutoEn    = 1'b1;
      for (int i = 0; i < 7; i++) begin
        frameEdge();
        checkOutput("auto_hold_odd", 32'(ModeOut), 32'(prevMode));
        frameEdge();
        checkOutput("auto_mode", 32'(ModeOut), 32'(autoModes[i]));
        checkOutput("auto_display", 32'(Display), 32'(autoDisps[i]));
        prevMode = autoModes[i];
      end
      checkOutput("auto_thresh1", 32'(Thresh1), 200);
      checkOutput("auto_thresh2", 32'(Thresh2), 255);
      frameEdge();
      AutoEn = 1'b0;
      tick(2);
      repeat (3) frameEdge();
      checkOutput("auto_frozen", 32'(ModeOut), 0);
      AutoEn = 1'b1;
      frameEdge();
      checkOutput("auto_count_cleared", 32'(ModeOut), 0);
      frameEdge();
      checkOutput("auto_resume", 32'(ModeOut), 1);
      RST = 1'b0;
      VSync = 1'b1;
      tick(2);
      RST = 1'b1;
      tick(3);
      VSync = 1'b0;
      tick(2);
      frameEdge();
      checkOutput("auto_no_false_edge", 32'(ModeOut), 0);
      AutoEn = 1'b0;
    end
`else
    AutoEn = 1'b1;
    repeat (4) frameEdge();
    checkOutput("noauto_mode_fixed", 32'(ModeOut), 0);
    checkOutput("noauto_display_fixed", 32'(Display), 0);
    AutoEn = 1'b0;
`endif

    tick(3);
    checkOutput("sb_empty", 32'(sbQueue.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
